fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall  input  1  downstream (IF/ID) cannot accept an instruction this cycle.
REQ-005 SHALL have port redirect  input  1  branch/jump resolved taken; abandon current fetch stream.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  request address; held stable while imem_req=1 and imem_ready=0.
REQ-009 SHALL have port imem_ready  input  1  imem_rdata valid and request retired this cycle.
REQ-010 SHALL have port imem_rdata  input  32  instruction word.
REQ-011 SHALL have port fetch_valid  output  1  instruction delivered to IF/ID this cycle.
REQ-012 SHALL have port fetch_pc  output  32  PC+4 of delivered instruction.
REQ-013 SHALL have port fetch_instr  output  32  delivered instruction word.
REQ-014 SHALL have port fetch_jump  output  32  J-type target {fetch_pc[31:28], fetch_instr[25:0], 2'b00}.
REQ-015 SHALL have port fetch_count  output  32  number of instructions delivered.

Function
REQ-016 SHALL implement states FETCH, HOLD, DROP; registers pc, hold_instr, drop_pc, fetch_count.
REQ-017 FETCH: imem_req=1, imem_addr=pc.
REQ-018 FETCH, imem_ready=1, redirect=0, stall=0: fetch_valid=1 same cycle (combinational from imem_rdata), fetch_pc=pc+4; next pc=pc+4, fetch_count+1; remain FETCH.
REQ-019 FETCH, imem_ready=1, redirect=0, stall=1: capture imem_rdata into hold_instr; fetch_valid=0; pc unchanged; go HOLD.
REQ-020 FETCH, imem_ready=1, redirect=1: discard imem_rdata; fetch_valid=0; next pc=redirect_pc; remain FETCH.
REQ-021 FETCH, imem_ready=0, redirect=1: drop_pc<=redirect_pc; go DROP (imem_addr must stay at old pc).
REQ-022 FETCH, imem_ready=0, redirect=0: hold address, no state change, stall irrelevant.
REQ-023 HOLD: imem_req=0; if redirect=1 discard hold_instr, pc<=redirect_pc, go FETCH; else if stall=0 deliver hold_instr (fetch_valid=1, fetch_pc=pc+4), pc<=pc+4, fetch_count+1, go FETCH; else stay.
REQ-024 DROP: imem_req=1, imem_addr=pc (old); redirect=1 overwrites drop_pc (latest wins); on imem_ready=1 discard data, pc<=latest target (redirect_pc if redirect=1 this cycle, else drop_pc), go FETCH.
REQ-025 Priority: redirect over stall over delivery in every state.
REQ-026 fetch_valid=0 in DROP and whenever no delivery occurs; then fetch_instr=32'h0 (NOP), fetch_pc=32'h0, fetch_jump=32'h0.
REQ-027 pc+4 and fetch_count SHALL wrap modulo 2^32; redirect_pc not alignment-checked.
REQ-028 At most one instruction delivered per cycle; no instruction delivered twice or lost except by redirect.

Reset
REQ-029 rst=1 SHALL immediately force state=FETCH, pc=RESET_PC, hold_instr=0, drop_pc=0, fetch_count=0, imem_req=0, fetch_valid=0, regardless of clk.
REQ-030 First rising edge after rst deasserts: imem_req=1, imem_addr=RESET_PC; reset mid-wait abandons outstanding request with no delivery.

Verification
REQ-031 Zero-wait imem, no stall, 4 cycles -> fetch_pc 4,8,12,16; fetch_count=4.
REQ-032 imem_ready=1 with stall=1 for 3 cycles at pc=8 -> HOLD, imem_req=0; stall drops -> hold_instr delivered, fetch_pc=12, next addr=12.
REQ-033 imem waiting at pc=16, redirect to 0x100 then 0x200 before ready -> addr held 16, data discarded, next addr=0x200, no fetch_valid.
REQ-034 redirect=1 and stall=1 in HOLD with redirect_pc=0x40 -> buffer discarded, next addr=0x40, fetch_count unchanged.
REQ-035 imem_rdata=32'h0800_0010 delivered at pc=0x1000_0000 -> fetch_jump=32'h1000_0040.
REQ-036 rst asserted between clock edges while waiting -> outputs reset at once; after release addr=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid buffer
// for downstream stalls, and redirect handling while a request is still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_jump,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] drop_pc_q, drop_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        req_en_q;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_instr_q  <= 32'h0;
      drop_pc_q     <= 32'h0;
      fetch_count_q <= 32'h0;
      req_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      drop_pc_q     <= drop_pc_d;
      fetch_count_q <= fetch_count_d;
      req_en_q      <= 1'b1;
    end
  end

  // req_en_q keeps the request low until the first clock edge after reset release.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    drop_pc_d     = drop_pc_q;
    fetch_count_d = fetch_count_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    deliver       = 1'b0;
    deliver_instr = 32'h0;

    case (state_q)
      FETCH: begin
        imem_req = req_en_q;
        if (req_en_q) begin
          if (imem_ready) begin
            if (redirect) begin
              pc_d = redirect_pc;
            end else if (stall) begin
              hold_instr_d = imem_rdata;
              state_d      = HOLD;
            end else begin
              deliver       = 1'b1;
              deliver_instr = imem_rdata;
              pc_d          = pc_plus4;
              fetch_count_d = fetch_count_q + 32'd1;
            end
          end else if (redirect) begin
            // Address must stay put until the in-flight request retires.
            drop_pc_d = redirect_pc;
            state_d   = DROP;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          hold_instr_d = 32'h0;
          pc_d         = redirect_pc;
          state_d      = FETCH;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          pc_d          = pc_plus4;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end
      end

      DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          drop_pc_d = redirect_pc;
        end
        if (imem_ready) begin
          pc_d    = redirect ? redirect_pc : drop_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign fetch_valid = deliver;
  assign fetch_pc    = deliver ? pc_plus4 : 32'h0;
  assign fetch_instr = deliver_instr;
  assign fetch_jump  = deliver ? {pc_plus4[31:28], deliver_instr[25:0], 2'b00} : 32'h0;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/hold, redirect during wait,
// redirect in hold, jump target, wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_jump;
  logic [31:0] fetch_count;

  int checks_cnt;
  int errors_cnt;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_jump  (fetch_jump),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic stl,
                       input logic redir, input logic [31:0] rpc);
    imem_ready  = rdy;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;

    #2;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_count", fetch_count, 32'h0);

    tick();
    rst = 1'b0;
    tick();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);

    // Zero-wait streaming, four instructions
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 32'h0);
      check("stream_valid", {31'b0, fetch_valid}, 32'h1);
      check("stream_pc", fetch_pc, 32'(4 * (k + 1)));
      check("stream_instr", fetch_instr, 32'hA000_0000 + 32'(k));
      tick();
    end
    check("stream_count", fetch_count, 32'd4);
    check("stream_addr", imem_addr, 32'd16);

    // Redirect with ready=1 to reach pc=8
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8);
    check("redir_rdy_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    check("redir_rdy_addr", imem_addr, 32'h8);

    // Stall with data ready: capture into hold, then three stalled cycles total
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    check("stall_cap_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("hold_req", {31'b0, imem_req}, 32'h0);
      check("hold_valid", {31'b0, fetch_valid}, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("hold_deliver_valid", {31'b0, fetch_valid}, 32'h1);
    check("hold_deliver_pc", fetch_pc, 32'd12);
    check("hold_deliver_instr", fetch_instr, 32'h1234_5678);
    tick();
    check("hold_next_addr", imem_addr, 32'd12);
    check("hold_count", fetch_count, 32'd5);

    // Deliver at 12 to reach pc=16
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    check("pc12_pc", fetch_pc, 32'd16);
    tick();

    // Waiting at 16, two redirects before ready
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    check("drop1_addr", imem_addr, 32'd16);
    check("drop1_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    check("drop2_addr", imem_addr, 32'd16);
    check("drop2_req", {31'b0, imem_req}, 32'h1);
    tick();
    drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 32'h0);
    check("drop_ret_valid", {31'b0, fetch_valid}, 32'h0);
    check("drop_ret_addr", imem_addr, 32'd16);
    tick();
    check("drop_next_addr", imem_addr, 32'h200);
    check("drop_count", fetch_count, 32'd6);

    // Redirect and stall together while in HOLD
    drive(1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    check("hold_redir_valid", {31'b0, fetch_valid}, 32'h0);
    check("hold_redir_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("hold_redir_addr", imem_addr, 32'h40);
    check("hold_redir_req1", {31'b0, imem_req}, 32'h1);
    check("hold_redir_count", fetch_count, 32'd6);

    // Jump target composition
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h1000_0000);
    tick();
    drive(1'b1, 32'h0800_0010, 1'b0, 1'b0, 32'h0);
    check("jump_pc", fetch_pc, 32'h1000_0004);
    check("jump_target", fetch_jump, 32'h1000_0040);
    tick();
    drive(1'b0, 32'h0800_0010, 1'b0, 1'b0, 32'h0);
    check("idle_instr", fetch_instr, 32'h0);
    check("idle_pc", fetch_pc, 32'h0);
    check("idle_jump", fetch_jump, 32'h0);

    // PC wrap at top of address space
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0);
    check("wrap_valid", {31'b0, fetch_valid}, 32'h1);
    check("wrap_pc", fetch_pc, 32'h0);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_count", fetch_count, 32'd8);

    // Asynchronous reset between edges while waiting
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0);
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_valid", {31'b0, fetch_valid}, 32'h0);
    check("arst_count", fetch_count, 32'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("arst_addr", imem_addr, 32'h0);
    check("arst_req1", {31'b0, imem_req}, 32'h1);
    check("arst_count1", fetch_count, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
